kernel3x3_engine: RTL and testbench

- Parametrised 3x3 neighbourhood filter engine; next generation of the single-kernel calc stage.
- Sits between the line-buffer window generator (supplies d0..d8, row-major, d4 = centre) and the output pixel writer.
- Runtime-selectable kernel: passthrough, Gaussian, Sobel magnitude, emboss. Optional binarising threshold.
- Fixed 3-stage pipeline; mode is tagged per sample so the mode can change mid-stream without a pipeline flush.

---
 rtl/kernel3x3_engine.sv | 132 +++++++++++++
 tb/tb_kernel3x3_engine.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/kernel3x3_engine.sv
// 3x3 neighbourhood filter: pass / gauss / sobel magnitude / emboss with optional binarising threshold.
// The mode is carried with each sample, so it can change mid-stream; the window is captured at edge N and the result is on data_o after edge N+3.
module kernel3x3_engine #(
  parameter int DW = 8,
  parameter int IW = DW + 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d0_i,
  input  logic [DW-1:0] d1_i,
  input  logic [DW-1:0] d2_i,
  input  logic [DW-1:0] d3_i,
  input  logic [DW-1:0] d4_i,
  input  logic [DW-1:0] d5_i,
  input  logic [DW-1:0] d6_i,
  input  logic [DW-1:0] d7_i,
  input  logic [DW-1:0] d8_i,
  input  logic          done_i,
  input  logic [1:0]    mode_i,
  input  logic          mode_ld_i,
  input  logic          bin_en_i,
  input  logic [DW-1:0] thr_i,
  output logic [DW-1:0] data_o,
  output logic          done_o,
  output logic          busy_o
);

  localparam int STAGES = 3;
  localparam logic signed [IW-1:0] HALF = {{(IW-DW){1'b0}}, 1'b1, {(DW-1){1'b0}}};
  localparam logic signed [IW-1:0] MAXV = {{(IW-DW){1'b0}}, {DW{1'b1}}};

  typedef enum logic [1:0] {M_PASS = 2'd0, M_GAUSS = 2'd1, M_SOBEL = 2'd2, M_EMBOSS = 2'd3} mode_t;
  typedef struct packed {
    logic          bin;
    logic [DW-1:0] thr;
  } thr_t;

  mode_t                mode_q, mode_eff, mode1;
  thr_t                 tag1, tag2;
  logic [STAGES:1]      vld_pipe;
  logic [DW-1:0]        d [9];
  logic signed [IW-1:0] p [9];
  logic signed [IW-1:0] a_nxt, b_nxt, s1_a, s1_b, s1_c;
  logic signed [IW:0]   gsum;
  logic signed [IW-1:0] abs_a, abs_b, r_nxt, r2;
  logic [DW-1:0]        cl, q_nxt, q3;

  // A mode load in the same cycle as a sample applies to that sample.
  assign mode_eff = mode_ld_i ? mode_t'(mode_i) : mode_q;
  assign busy_o   = |vld_pipe;

  always_comb begin
    d = '{d0_i, d1_i, d2_i, d3_i, d4_i, d5_i, d6_i, d7_i, d8_i};
    for (int k = 0; k < 9; k++) p[k] = $signed({{(IW-DW){1'b0}}, d[k]});
  end

  // Stage 1: partial sums of the selected kernel
  always_comb begin
    a_nxt = p[4];
    b_nxt = '0;
    unique case (mode_eff)
      M_PASS:   a_nxt = p[4];
      M_GAUSS: begin
        a_nxt = p[0] + p[2] + p[6] + p[8];
        b_nxt = p[1] + p[3] + p[5] + p[7];
      end
      M_SOBEL: begin
        a_nxt = (p[2] + p[5] + p[5] + p[8]) - (p[0] + p[3] + p[3] + p[6]);
        b_nxt = (p[6] + p[7] + p[7] + p[8]) - (p[0] + p[1] + p[1] + p[2]);
      end
      M_EMBOSS: a_nxt = p[4] + p[5] - p[3] - p[1] + p[8] + p[8] - p[0] - p[0] + p[7];
    endcase
  end

  // Stage 2: the gauss sum reaches 16*(2^DW-1), so it gets one extra bit
  always_comb begin
    gsum  = (IW+1)'(s1_a) + (IW+1)'(s1_b) + (IW+1)'(s1_b) + ((IW+1)'(s1_c) <<< 2);
    abs_a = s1_a[IW-1] ? -s1_a : s1_a;
    abs_b = s1_b[IW-1] ? -s1_b : s1_b;
    r_nxt = s1_c;
    unique case (mode1)
      M_PASS:   r_nxt = s1_c;
      M_GAUSS:  r_nxt = IW'(gsum >>> 4);
      M_SOBEL:  r_nxt = abs_a + abs_b;
      M_EMBOSS: r_nxt = s1_a + HALF;
    endcase
  end

  // Stage 3: clamp to pixel range, then optional threshold
  always_comb begin
    if (r2[IW-1])        cl = '0;
    else if (r2 > MAXV)  cl = {DW{1'b1}};
    else                 cl = r2[DW-1:0];
    q_nxt = cl;
    if (tag2.bin) q_nxt = (cl >= tag2.thr) ? {DW{1'b1}} : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= M_PASS;
      mode1    <= M_PASS;
      tag1     <= '0;
      tag2     <= '0;
      vld_pipe <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
      r2       <= '0;
      q3       <= '0;
      data_o   <= '0;
      done_o   <= 1'b0;
    end else begin
      if (mode_ld_i) mode_q <= mode_t'(mode_i);
      vld_pipe <= {vld_pipe[STAGES-1:1], done_i};
      if (done_i) begin
        mode1 <= mode_eff;
        tag1  <= '{bin: bin_en_i, thr: thr_i};
        s1_a  <= a_nxt;
        s1_b  <= b_nxt;
        s1_c  <= p[4];
      end
      if (vld_pipe[1]) begin
        tag2 <= tag1;
        r2   <= r_nxt;
      end
      if (vld_pipe[2]) q3 <= q_nxt;
      done_o <= vld_pipe[3];
      if (vld_pipe[3]) data_o <= q3;
    end
  end

endmodule

// File: tb/tb_kernel3x3_engine.sv
// Bench for kernel3x3_engine: directed windows with literal results, checked each cycle against an arithmetic model.
module tb_kernel3x3_engine;
  localparam int DW   = 8;
  localparam int MAXP = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] pix [9];
  logic          done_i = 1'b0, mode_ld = 1'b0, bin_en = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] thr = '0;
  logic [DW-1:0] data_o;
  logic          done_o, busy_o;

  always #5 clk = ~clk;

  kernel3x3_engine #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .d0_i(pix[0]), .d1_i(pix[1]), .d2_i(pix[2]), .d3_i(pix[3]), .d4_i(pix[4]),
    .d5_i(pix[5]), .d6_i(pix[6]), .d7_i(pix[7]), .d8_i(pix[8]),
    .done_i(done_i), .mode_i(mode), .mode_ld_i(mode_ld), .bin_en_i(bin_en), .thr_i(thr),
    .data_o(data_o), .done_o(done_o), .busy_o(busy_o)
  );

  typedef struct {
    int due;
    int val;
    int lit;
  } exp_t;

  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, last_smp = 0, cur_lit = -1;
  exp_t q [$];

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Kernel results straight from the defining formulas, in plain integers.
  function automatic int golden(int m, int p[9], bit be, int th);
    int r, gx, gy;
    case (m)
      1: r = (p[0] + p[2] + p[6] + p[8] + 2*(p[1] + p[3] + p[5] + p[7]) + 4*p[4]) / 16;
      2: begin
        gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        r  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      end
      3: r = p[4] + p[5] - p[3] - p[1] + 2*p[8] - 2*p[0] + p[7] + (1 << (DW-1));
      default: r = p[4];
    endcase
    if (r < 0) r = 0;
    else if (r > MAXP) r = MAXP;
    if (be) r = (r >= th) ? MAXP : 0;
    return r;
  endfunction

  // Model update on each rising edge, output comparison on the following falling edge.
  always begin : mdl
    int   p [9];
    exp_t e;
    int   bz;
    int   mode_m;
    int   last_out;
    bit   armed;
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      mode_m   = 0;
      last_out = 0;
      armed    = 1'b1;
    end else begin
      if (mode_ld) mode_m = int'(mode);
      if (done_i) begin
        for (int k = 0; k < 9; k++) p[k] = int'(pix[k]);
        e.due = cyc + 3;
        e.val = golden(mode_m, p, bin_en, int'(thr));
        e.lit = cur_lit;
        q.push_back(e);
      end
    end
    @(negedge clk);
    if (armed) begin
      bz = 0;
      foreach (q[i]) if (q[i].due - 3 <= cyc && cyc < q[i].due) bz = 1;
      check("busy_o", busy_o, bz);
      if (q.size() > 0 && q[0].due == cyc) begin
        check("done_o pulse", done_o, 1);
        check("data_o vs model", data_o, q[0].val);
        if (q[0].lit >= 0) check("data_o vs literal", data_o, q[0].lit);
        last_out = q[0].val;
        void'(q.pop_front());
      end else begin
        check("done_o idle", done_o, 0);
        check("data_o hold", data_o, last_out);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit ld, input int m, input int px[9], input bit be, input int th, input int lit);
    for (int k = 0; k < 9; k++) pix[k] = DW'(px[k]);
    mode_ld = ld;
    mode    = 2'(m);
    bin_en  = be;
    thr     = DW'(th);
    cur_lit = lit;
    done_i  = 1'b1;
    tick();
    done_i   = 1'b0;
    mode_ld  = 1'b0;
    cur_lit  = -1;
    last_smp = cyc;
  endtask

  function automatic void fill(output int px[9], input int v);
    for (int k = 0; k < 9; k++) px[k] = v;
  endfunction

  initial begin
    int px [9];
    int bc, lat;
    for (int k = 0; k < 9; k++) pix[k] = '0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset data_o", data_o, 0);
    check("reset done_o", done_o, 0);
    check("reset busy_o", busy_o, 0);

    // pass sample: latency and busy window
    for (int k = 0; k < 9; k++) px[k] = $urandom_range(0, MAXP);
    px[4] = 'h5A;
    send(0, 0, px, 0, 0, 'h5A);
    bc = 0;
    lat = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (busy_o === 1'b1) bc++;
      if (done_o === 1'b1 && lat < 0) lat = cyc - last_smp;
    end
    check("pass latency", lat, 3);
    check("busy cycles", bc, 3);

    fill(px, 100);  send(1, 1, px, 0, 0, 100);
    fill(px, 0);    px[4] = 255; send(0, 1, px, 0, 0, 63);
    px = '{0, 128, 255, 0, 128, 255, 0, 128, 255};
    send(1, 2, px, 0, 0, 255);
    fill(px, 77);   send(0, 2, px, 0, 0, 0);
    fill(px, 50);   send(1, 3, px, 0, 0, 178);
    fill(px, 0);    px[0] = 255; send(0, 3, px, 0, 0, 0);
    repeat (5) tick();

    // mode switch to sobel on sample 3 of a contiguous gauss stream
    fill(px, 100);
    send(1, 1, px, 0, 0, 100);
    send(0, 1, px, 0, 0, 100);
    send(1, 2, px, 0, 0, 0);
    for (int k = 0; k < 3; k++) send(0, 2, px, 0, 0, 0);
    repeat (5) tick();

    fill(px, 149);  send(1, 1, px, 1, 150, 0);
    fill(px, 150);  send(0, 1, px, 1, 150, 255);
    repeat (5) tick();

    // bubbles in the input must reappear with the same spacing
    for (int k = 0; k < 9; k++) px[k] = $urandom_range(0, MAXP);
    send(1, 3, px, 0, 0, -1);
    tick();
    tick();
    send(0, 3, px, 0, 0, -1);
    tick();
    send(1, 2, px, 0, 0, -1);
    repeat (5) tick();

    for (int n = 0; n < 24; n++) begin
      for (int k = 0; k < 9; k++) px[k] = $urandom_range(0, MAXP);
      send(bit'($urandom_range(0, 1)), $urandom_range(0, 3), px, bit'($urandom_range(0, 1)),
           $urandom_range(0, MAXP), -1);
      if ($urandom_range(0, 2) == 0) tick();
    end
    repeat (5) tick();

    // reset with two samples in flight, then a sample on the first free cycle
    fill(px, 3);    px[4] = 'h77; send(1, 0, px, 0, 0, 'h77);
    repeat (4) tick();
    fill(px, 200);
    send(1, 1, px, 0, 0, -1);
    send(0, 1, px, 0, 0, -1);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("mid-reset data_o", data_o, 0);
    check("mid-reset done_o", done_o, 0);
    rst = 1'b0;
    fill(px, 9);    px[4] = 33; send(0, 0, px, 0, 0, 33);
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
